// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
// The widths of the write port and the size of the register file are defined here.
package rf_pkg;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 1 << ADDR_W;

  // Register 0 reads as zero, so writes to it are dropped.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // One candidate write to the register file.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO that buffers load returns.
// The head entry is readable combinationally, so the arbiter can pop it in the
// same cycle that it selects it. DEPTH must be a power of two so that the
// pointers wrap on their own.
module rf_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses a push, even in a cycle where it is also popping.
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // The storage array is not reset; the occupancy count determines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU result path
// and buffered load returns. ALU results have priority. The module also keeps a
// pending-write scoreboard that drives the issue-stage RAW hazard outputs.
// The data and address widths come from rf_pkg.
// Optional: define RF_WB_ERR_CHECK_EN to add a sticky protocol-error output, err.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] chk_addr0,
  input  logic [ADDR_W-1:0] chk_addr1,
  output logic              hazard0,
  output logic              hazard1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_in,
  output logic [DATA_W-1:0] wr_data_in
`ifdef RF_WB_ERR_CHECK_EN
  ,
  output logic              err
`endif
);

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  wb_req_t                  sel;
  logic                     wr_en_reg;
  logic [ADDR_W-1:0]        wr_addr_reg;
  logic [DATA_W-1:0]        wr_data_reg;
  logic [REG_COUNT-1:0]     pending_reg;

  assign ld_ready  = !fifo_full;
  assign fifo_push = ld_valid && !fifo_full;
  // The FIFO head is consumed only when the ALU leaves the write port free.
  assign fifo_pop  = !alu_valid && !fifo_empty;

  rf_wb_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({ld_addr, ld_data}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fixed-priority selection: an ALU result wins; otherwise the FIFO head is selected.
  always_comb begin
    sel = '0;
    if (alu_valid) begin
      sel.valid = 1'b1;
      sel.addr  = alu_addr;
      sel.data  = alu_data;
    end else if (!fifo_empty) begin
      sel.valid = 1'b1;
      {sel.addr, sel.data} = fifo_head;
    end
  end

  // Register the selection onto the RF write port. A write to r0 consumes its slot but does not assert wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= sel.valid && (sel.addr != ZERO_REG);
      if (sel.valid) begin
        wr_addr_reg <= sel.addr;
        wr_data_reg <= sel.data;
      end
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr_in = wr_addr_reg;
  assign wr_data_in = wr_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign pending_reg[gi] = 1'b0;
      end else begin : g_bit
        // A new issue takes precedence over a retiring write to the same register.
        always_ff @(posedge clk) begin
          if (reset) begin
            pending_reg[gi] <= 1'b0;
          end else if (iss_valid && iss_dst == ADDR_W'(gi)) begin
            pending_reg[gi] <= 1'b1;
          end else if (wr_en_reg && wr_addr_reg == ADDR_W'(gi)) begin
            pending_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // The RF forwards the write it is currently receiving, so that write is not reported as a hazard.
  assign hazard0 = (chk_addr0 != ZERO_REG) && pending_reg[chk_addr0]
                   && !(wr_en_reg && wr_addr_reg == chk_addr0);
  assign hazard1 = (chk_addr1 != ZERO_REG) && pending_reg[chk_addr1]
                   && !(wr_en_reg && wr_addr_reg == chk_addr1);

`ifdef RF_WB_ERR_CHECK_EN
  logic err_reg;

  // Sticky flag for double issue, an unexpected write, or a load offered to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if ((iss_valid && iss_dst != ZERO_REG && pending_reg[iss_dst])
              || (sel.valid && sel.addr != ZERO_REG && !pending_reg[sel.addr])
              || (ld_valid && fifo_full)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule
